parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Parametrised successor to the single-gate car park controller. It runs the entrance gate FSM with a configurable password width, and it tracks occupancy up to a configurable capacity. It refuses entry when the car park is full and locks the gate out for a set time after repeated wrong passwords. It drives the gate LEDs and two 7-segment digits directly, and it exports occupancy to the display/supervisor logic.

## Interface
- CAPACITY, 8: number of spaces (≥1); CNT_W = $clog2(CAPACITY+1)
- PW_WIDTH, 2: width of each password digit
- PASSWORD_1, 1: expected first digit
- PASSWORD_2, 2: expected second digit
- WAIT_CYCLES, 16: cycles allowed for a password submission before timeout (≥2)
- MAX_TRIES, 3: wrong submissions that trigger lockout (≥1)
- LOCK_CYCLES, 32: lockout duration in cycles (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- sensor_entrance  in  1  car waiting at entrance (level)
- sensor_exit  in  1  car has passed through the entrance gate (level)
- sensor_leave  in  1  one-cycle pulse: a car left via the departure lane
- password_1  in  PW_WIDTH  first digit
- password_2  in  PW_WIDTH  second digit
- pw_valid  in  1  one-cycle pulse: sample password_1/2 this cycle
- GREEN_LED  out  1  gate open indicator
- RED_LED  out  1  gate closed / error indicator
- HEX_1  out  7  digit 1, active-low, bit6..0 = g..a
- HEX_2  out  7  digit 2, same encoding
- occupancy  out  CNT_W  cars inside
- full  out  1  occupancy == CAPACITY
- locked  out  1  FSM in LOCKOUT

## Operation

FSM states and transitions:
- IDLE
  - sensor_entrance & !full → WAIT_PASSWORD
  - sensor_entrance & full → FULL
- WAIT_PASSWORD
  - pw_valid with both digits correct → RIGHT_PASS
  - pw_valid with any digit wrong → WRONG_PASS, tries+1
  - timeout → IDLE
- WRONG_PASS
  - if tries == MAX_TRIES → LOCKOUT, regardless of inputs
  - otherwise the same rules as WAIT_PASSWORD apply
- RIGHT_PASS
  - sensor_exit & sensor_entrance → occupancy+1; then WAIT_PASSWORD if the new occupancy < CAPACITY, else FULL
  - sensor_exit & !sensor_entrance → occupancy+1, → IDLE
- FULL: !sensor_entrance → IDLE; !full & sensor_entrance → WAIT_PASSWORD
- LOCKOUT: after LOCK_CYCLES cycles → IDLE; all inputs except sensor_leave are ignored

Counters and registers:
- tries: clears on entry to RIGHT_PASS, IDLE or LOCKOUT.
- wait timer: reloads on every entry to WAIT_PASSWORD/WRONG_PASS and on every pw_valid. Timeout is WAIT_CYCLES cycles with no pw_valid.
- occupancy:
  - decrements on sensor_leave, saturating at 0.
  - increment and decrement in the same cycle leave it unchanged.
  - increment never exceeds CAPACITY.
  - sensor_leave is honoured in every state.
- blink register: toggles every cycle while in WRONG_PASS or RIGHT_PASS; clears otherwise.

Outputs are a Moore decode of the state register:
- IDLE: LEDs 0/0, HEX 7'h7F/7'h7F (blank)
- WAIT_PASSWORD: RED=1, GREEN=0, HEX "E","n" = 7'b0000110 / 7'b0101011
- WRONG_PASS: RED=blink, GREEN=0, HEX "E","E"
- RIGHT_PASS: GREEN=blink, RED=0, HEX "6","0" = 7'b0000010 / 7'b1000000
- FULL: RED=1, HEX "F","U" = 7'b0001110 / 7'b1000001
- LOCKOUT: RED=1, HEX "L","0" = 7'b1000111 / 7'b1000000

## Timing
- Reset values: state=IDLE, occupancy=0, tries=0, timers=0, blink=0. Outputs are then GREEN_LED=0, RED_LED=0, HEX_1=HEX_2=7'h7F, full=0, locked=0.
- Reset asserted mid-operation returns everything to the reset values immediately; occupancy is lost.
- State changes on the clk edge where its condition is sampled. Outputs reflect the new state in the same cycle the state register holds it (1-cycle latency from input to LEDs).
- occupancy/full update on the same edge as the RIGHT_PASS exit or the sensor_leave pulse.
- pw_valid outside WAIT_PASSWORD/WRONG_PASS is ignored.
- Blink in its first cycle in the state = 0, then 1, 0, and so on.
- Lockout lasts exactly LOCK_CYCLES cycles in LOCKOUT. Timeout leaves WAIT on the WAIT_CYCLES-th cycle without pw_valid.

## Test plan
- Reset, sensor_entrance=1, pw_valid with 1/2 → RED=1 then GREEN blinking 0,1,0…; sensor_exit=1 → IDLE, occupancy=1.
- Three wrong submissions (0/0) with MAX_TRIES=3 → locked=1, HEX "L0" for 32 cycles; pw_valid with 1/2 ignored; then IDLE, tries=0.
- Fill to CAPACITY=8, then sensor_entrance → FULL, full=1, HEX "FU". A sensor_leave pulse → occupancy=7, FSM → WAIT_PASSWORD while sensor_entrance is held.
- RIGHT_PASS with sensor_exit & sensor_entrance together → occupancy+1, straight to WAIT_PASSWORD (FULL if that fills the car park).
- Increment coinciding with a sensor_leave pulse → occupancy unchanged. sensor_leave at occupancy=0 → stays 0.
- WAIT_PASSWORD with no pw_valid for 16 cycles → IDLE. Reset asserted in RIGHT_PASS → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Entrance gate controller: password FSM with retry lockout, occupancy
// tracking against a fixed capacity, LED and 7-segment drive.
module parking_gate_controller #(
   parameter  int CAPACITY    = 8,
   parameter  int PW_WIDTH    = 2,
   parameter  int PASSWORD_1  = 1,
   parameter  int PASSWORD_2  = 2,
   parameter  int WAIT_CYCLES = 16,
   parameter  int MAX_TRIES   = 3,
   parameter  int LOCK_CYCLES = 32,
   localparam int CNT_W       = $clog2(CAPACITY + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sensor_entrance,
   input  logic                sensor_exit,
   input  logic                sensor_leave,
   input  logic [PW_WIDTH-1:0] password_1,
   input  logic [PW_WIDTH-1:0] password_2,
   input  logic                pw_valid,
   output logic                GREEN_LED,
   output logic                RED_LED,
   output logic [6:0]          HEX_1,
   output logic [6:0]          HEX_2,
   output logic [CNT_W-1:0]    occupancy,
   output logic                full,
   output logic                locked,
   output logic [2:0]          state_dbg_o
);

   localparam int WT_W = $clog2(WAIT_CYCLES);
   localparam int LK_W = $clog2(LOCK_CYCLES + 1);
   localparam int TR_W = $clog2(MAX_TRIES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_WRONG = 3'd2,
      S_RIGHT = 3'd3,
      S_FULL  = 3'd4,
      S_LOCK  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic [TR_W-1:0]  tries_q, tries_d;
   logic [WT_W-1:0]  wait_q, wait_d;
   logic [LK_W-1:0]  lock_q, lock_d;
   logic             blink_q, blink_d;
   logic             full_w, inc_w, pw_ok_w, entering_w;

   assign full_w  = (occ_q == CNT_W'(CAPACITY));
   assign inc_w   = (state_q == S_RIGHT) && sensor_exit;
   assign pw_ok_w = (password_1 == PW_WIDTH'(PASSWORD_1)) &&
                    (password_2 == PW_WIDTH'(PASSWORD_2));

   // A car entering and one leaving in the same cycle cancel out.
   always_comb begin
      occ_d = occ_q;
      if (inc_w && !sensor_leave && (occ_q < CNT_W'(CAPACITY)))
         occ_d = occ_q + CNT_W'(1);
      else if (sensor_leave && !inc_w && (occ_q != '0))
         occ_d = occ_q - CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      wait_d  = wait_q;
      lock_d  = lock_q;
      case (state_q)
         S_IDLE: begin
            if (sensor_entrance) state_d = full_w ? S_FULL : S_WAIT;
         end
         S_WAIT, S_WRONG: begin
            if ((state_q == S_WRONG) && (tries_q == TR_W'(MAX_TRIES))) begin
               state_d = S_LOCK;
            end else if (pw_valid) begin
               if (pw_ok_w) begin
                  state_d = S_RIGHT;
               end else begin
                  state_d = S_WRONG;
                  tries_d = tries_q + TR_W'(1);
               end
            end else if (wait_q == WT_W'(WAIT_CYCLES - 1)) begin
               state_d = S_IDLE;
            end else begin
               wait_d = wait_q + WT_W'(1);
            end
         end
         S_RIGHT: begin
            if (sensor_exit) begin
               if (!sensor_entrance)                 state_d = S_IDLE;
               else if (occ_d < CNT_W'(CAPACITY))    state_d = S_WAIT;
               else                                  state_d = S_FULL;
            end
         end
         S_FULL: begin
            if (!sensor_entrance) state_d = S_IDLE;
            else if (!full_w)     state_d = S_WAIT;
         end
         S_LOCK: begin
            if (lock_q == LK_W'(LOCK_CYCLES - 1)) state_d = S_IDLE;
            else                                   lock_d  = lock_q + LK_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      entering_w = (state_d != state_q);
      if (entering_w && (state_d == S_IDLE || state_d == S_RIGHT || state_d == S_LOCK))
         tries_d = '0;
      // Every submission restarts the window, including a repeat wrong one.
      if ((entering_w || pw_valid) && (state_d == S_WAIT || state_d == S_WRONG))
         wait_d = '0;
      if (state_d != S_WAIT && state_d != S_WRONG)
         wait_d = '0;
      if (state_d != S_LOCK || entering_w)
         lock_d = '0;
      blink_d = ((state_d == S_WRONG || state_d == S_RIGHT) && !entering_w) ? ~blink_q : 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         occ_q   <= '0;
         tries_q <= '0;
         wait_q  <= '0;
         lock_q  <= '0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         tries_q <= tries_d;
         wait_q  <= wait_d;
         lock_q  <= lock_d;
         blink_q <= blink_d;
      end
   end

   always_comb begin
      GREEN_LED = 1'b0;
      RED_LED   = 1'b0;
      HEX_1     = 7'h7F;
      HEX_2     = 7'h7F;
      case (state_q)
         S_WAIT:  begin RED_LED = 1'b1;    HEX_1 = 7'b0000110; HEX_2 = 7'b0101011; end
         S_WRONG: begin RED_LED = blink_q; HEX_1 = 7'b0000110; HEX_2 = 7'b0000110; end
         S_RIGHT: begin GREEN_LED = blink_q; HEX_1 = 7'b0000010; HEX_2 = 7'b1000000; end
         S_FULL:  begin RED_LED = 1'b1;    HEX_1 = 7'b0001110; HEX_2 = 7'b1000001; end
         S_LOCK:  begin RED_LED = 1'b1;    HEX_1 = 7'b1000111; HEX_2 = 7'b1000000; end
         default: ;
      endcase
   end

   assign occupancy   = occ_q;
   assign full        = full_w;
   assign locked      = (state_q == S_LOCK);
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: vector table for single-step behaviour,
// hand sequences for lockout, timeouts, filling and async reset.
module tb_parking_gate_controller;

   typedef enum int {T_IDLE, T_WAIT, T_WRONG, T_RIGHT, T_FULL, T_LOCK} tst_t;

   typedef struct {
      string      nm;
      logic       ent;
      logic       ext;
      logic       lv;
      logic       pv;
      logic [1:0] p1;
      logic [1:0] p2;
      tst_t       st;
      logic       bl;
      int         occ;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       sensor_entrance, sensor_exit, sensor_leave, pw_valid;
   logic [1:0] password_1, password_2;
   logic       GREEN_LED, RED_LED, full, locked;
   logic [6:0] HEX_1, HEX_2;
   logic [3:0] occupancy;
   logic [2:0] state_dbg_o;

   logic [21:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   vec_t        tbl[16];

   parking_gate_controller dut (
      .clk             (clk),
      .reset           (reset),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .sensor_leave    (sensor_leave),
      .password_1      (password_1),
      .password_2      (password_2),
      .pw_valid        (pw_valid),
      .GREEN_LED       (GREEN_LED),
      .RED_LED         (RED_LED),
      .HEX_1           (HEX_1),
      .HEX_2           (HEX_2),
      .occupancy       (occupancy),
      .full            (full),
      .locked          (locked),
      .state_dbg_o     (state_dbg_o)
   );

   always #5 clk = ~clk;

   // Expected outputs for a given state/blink/occupancy: {G, R, HEX1, HEX2, occ, full, locked}
   function automatic logic [21:0] mk(tst_t st, logic bl, int occ);
      logic       g, r;
      logic [6:0] h1, h2;
      g = 1'b0; r = 1'b0; h1 = 7'h7F; h2 = 7'h7F;
      case (st)
         T_WAIT:  begin r = 1'b1; h1 = 7'b0000110; h2 = 7'b0101011; end
         T_WRONG: begin r = bl;   h1 = 7'b0000110; h2 = 7'b0000110; end
         T_RIGHT: begin g = bl;   h1 = 7'b0000010; h2 = 7'b1000000; end
         T_FULL:  begin r = 1'b1; h1 = 7'b0001110; h2 = 7'b1000001; end
         T_LOCK:  begin r = 1'b1; h1 = 7'b1000111; h2 = 7'b1000000; end
         default: ;
      endcase
      return {g, r, h1, h2, 4'(occ), (occ == 8), (st == T_LOCK)};
   endfunction

   task automatic check(input string nm);
      logic [21:0] act, exp;
      act = {GREEN_LED, RED_LED, HEX_1, HEX_2, occupancy, full, locked};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got=%h", nm, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h (G R HEX1 HEX2 occ full locked)", nm, act, exp);
         end
      end
   endtask

   task automatic step(input string nm, input logic ent, input logic ext, input logic lv,
                       input logic pv, input logic [1:0] p1, input logic [1:0] p2,
                       input tst_t st, input logic bl, input int occ);
      @(negedge clk);
      sensor_entrance = ent;
      sensor_exit     = ext;
      sensor_leave    = lv;
      pw_valid        = pv;
      password_1      = p1;
      password_2      = p2;
      exp_q.push_back(mk(st, bl, occ));
      @(posedge clk);
      #1;
      check(nm);
   endtask

   // Three wrong submissions from IDLE (entrance held) then the full lockout window.
   task automatic lockout_run(input string nm);
      step({nm, "_wait"},   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT, 1'b0, 0);
      step({nm, "_wrong1"}, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, T_WRONG, 1'b0, 0);
      step({nm, "_wrong2"}, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, T_WRONG, 1'b1, 0);
      step({nm, "_wrong3"}, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, T_WRONG, 1'b0, 0);
      step({nm, "_enter"},  1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_LOCK, 1'b0, 0);
      for (int i = 1; i < 32; i++)
         step({nm, "_hold"}, 1'b1, 1'b0, 1'(i == 10), 1'(i % 2), 2'd1, 2'd2, T_LOCK, 1'b0, 0);
   endtask

   initial begin
      reset = 1'b1;
      sensor_entrance = 1'b0; sensor_exit = 1'b0; sensor_leave = 1'b0;
      pw_valid = 1'b0; password_1 = 2'd0; password_2 = 2'd0;

      tbl[0]  = '{"enter_wait",    1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT,  1'b0, 0};
      tbl[1]  = '{"pw_right",      1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, 0};
      tbl[2]  = '{"blink_1",       1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_RIGHT, 1'b1, 0};
      tbl[3]  = '{"blink_0",       1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_RIGHT, 1'b0, 0};
      tbl[4]  = '{"exit_idle",     1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE,  1'b0, 1};
      tbl[5]  = '{"enter_again",   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT,  1'b0, 1};
      tbl[6]  = '{"pw_wrong",      1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, T_WRONG, 1'b0, 1};
      tbl[7]  = '{"wrong_blink",   1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WRONG, 1'b1, 1};
      tbl[8]  = '{"wrong_to_right",1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, 1};
      tbl[9]  = '{"exit_and_ent",  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT,  1'b0, 2};
      tbl[10] = '{"digit2_wrong",  1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3, T_WRONG, 1'b0, 2};
      tbl[11] = '{"right_w_leave", 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, 1};
      tbl[12] = '{"inc_dec_same",  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, T_IDLE,  1'b0, 1};
      tbl[13] = '{"leave_dec",     1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, T_IDLE,  1'b0, 0};
      tbl[14] = '{"leave_sat0",    1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, T_IDLE,  1'b0, 0};
      tbl[15] = '{"pw_in_idle",    1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_IDLE,  1'b0, 0};

      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(mk(T_IDLE, 1'b0, 0));
      check("reset_state");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++)
         step(tbl[i].nm, tbl[i].ent, tbl[i].ext, tbl[i].lv, tbl[i].pv,
              tbl[i].p1, tbl[i].p2, tbl[i].st, tbl[i].bl, tbl[i].occ);

      // Lockout, then a second lockout shows the try count restarted at zero.
      lockout_run("lock_a");
      step("lock_a_exit", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE, 1'b0, 0);
      lockout_run("lock_b");
      step("lock_b_exit", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE, 1'b0, 0);

      // WAIT timeout: 16 cycles in WAIT, then IDLE.
      step("to_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT, 1'b0, 0);
      for (int i = 0; i < 15; i++)
         step("to_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT, 1'b0, 0);
      step("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE, 1'b0, 0);

      // WRONG timeout with a second wrong submission restarting the window.
      begin
         int j;
         j = 0;
         step("wt_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT, 1'b0, 0);
         step("wt_wrong", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, T_WRONG, 1'(j % 2), 0); j++;
         for (int i = 0; i < 7; i++) begin
            step("wt_hold", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WRONG, 1'(j % 2), 0); j++;
         end
         step("wt_reload", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, T_WRONG, 1'(j % 2), 0); j++;
         for (int i = 0; i < 15; i++) begin
            step("wt_hold2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WRONG, 1'(j % 2), 0); j++;
         end
         step("wt_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE, 1'b0, 0);
      end

      // Fill the car park with back-to-back entries.
      step("fill_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT, 1'b0, 0);
      for (int k = 1; k <= 8; k++) begin
         step("fill_right", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, k - 1);
         step("fill_pass",  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, (k < 8) ? T_WAIT : T_FULL, 1'b0, k);
      end
      step("full_noent",   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE,  1'b0, 8);
      step("full_refuse",  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_FULL,  1'b0, 8);
      step("full_leave",   1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, T_FULL,  1'b0, 7);
      step("full_to_wait", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_WAIT,  1'b0, 7);
      step("right_leave",  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, 6);
      step("right_blink",  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_RIGHT, 1'b1, 6);
      step("pass_w_leave", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, T_WAIT,  1'b0, 6);
      step("rst_prep",     1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, T_RIGHT, 1'b0, 6);

      // Asynchronous reset while in RIGHT_PASS: outputs clear before any edge.
      @(negedge clk);
      reset = 1'b1;
      sensor_entrance = 1'b0; sensor_exit = 1'b0; sensor_leave = 1'b0; pw_valid = 1'b0;
      #1;
      exp_q.push_back(mk(T_IDLE, 1'b0, 0));
      check("reset_async");
      @(posedge clk);
      #1;
      exp_q.push_back(mk(T_IDLE, 1'b0, 0));
      check("reset_held");
      @(negedge clk);
      reset = 1'b0;
      step("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, T_IDLE, 1'b0, 0);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
